ucore_mem_arbiter: RTL
======================

Name: ucore_mem_arbiter

Overview:
- Shares one memory bus port between NREQ generated microcoded cores.
- Arbitration is round-robin, one transaction outstanding at a time.
- Each accepted request is issued to memory, and the response or a timeout error is routed back to the owning core.
- Sits between the ucore_* instances and the single SRAM/bus bridge at the top of the design.

Parameters:
NREQ, 4, number of requesting cores (2..8)
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, cycles to wait for mem_rsp_valid before returning an error (1..65535)

Ports:
clk  input  1  global clock
aresetn  input  1  reset; one clock, asynchronous, active-low
req_valid  input  NREQ  per-core request valid
req_ready  output  NREQ  per-core request accepted, one-cycle pulse
req_addr  input  NREQ*AW  flattened per-core address, core i at [i*AW +: AW]
req_wen  input  NREQ  per-core write enable
req_wdata  input  NREQ*DW  flattened per-core write data
rsp_valid  output  NREQ  per-core response pulse
rsp_rdata  output  DW  response data, shared by all cores, qualified by rsp_valid
rsp_err  output  1  response is a timeout, qualified by rsp_valid
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  AW  memory address
mem_wen  output  1  memory write enable
mem_wdata  output  DW  memory write data
mem_rsp_valid  input  1  memory response (reads and writes both respond)
mem_rdata  input  DW  memory read data
busy  output  1  transaction in flight (state != IDLE)
err_spurious  output  1  sticky: mem_rsp_valid seen outside WAIT_RSP

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- On reset: state=IDLE, last_grant=NREQ-1 (core 0 has first priority), owner=0, timeout counter=0.
- Reset mid-transaction abandons the transaction. No response is delivered. Memory-side cleanup belongs to the bridge.
- Requester rule: once asserted, req_valid and its payload stay stable until req_ready. The bench checks this rule; it is not corrected.
- IDLE, cycle T, any req_valid high:
  - Winner = first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - Latch winner's addr/wen/wdata into mem_*; owner=last_grant=winner.
  - At T+1: req_ready[winner]=1 (single cycle), mem_req_valid=1, state=ISSUE.
- IDLE, no req_valid: stay IDLE; mem_req_valid=0.
- ISSUE:
  - mem_req_valid held with stable payload until mem_req_ready=1.
  - On handshake in cycle C: mem_req_valid=0 at C+1, state=WAIT_RSP, timeout counter cleared.
  - No timeout in ISSUE; the bus must eventually accept.
- WAIT_RSP:
  - Counter increments each cycle.
  - mem_rsp_valid in cycle R: at R+1, rsp_valid[owner]=1, rsp_rdata=mem_rdata, rsp_err=0, state=IDLE.
  - Counter reaches TIMEOUT with no response: next cycle rsp_valid[owner]=1, rsp_rdata=0, rsp_err=1, state=IDLE.
  - mem_rsp_valid in the same cycle the counter hits TIMEOUT: the response wins, rsp_err=0.
- rsp_valid, rsp_err and req_ready are single-cycle pulses, cleared to 0 the following cycle.
- The IDLE cycle that returns a response also performs arbitration.
  - Minimum turnaround: response at R, rsp_valid at R+1, next mem_req_valid at R+2.
- mem_rsp_valid in IDLE or ISSUE: ignored, err_spurious set to 1. Only reset clears it.
- mem_rsp_valid arriving after a timeout response is also spurious.
- Widths: counter is 16 bits. Owner and last_grant are clog2(NREQ) bits, with wrap at NREQ (non-power-of-2 supported).
- Fairness: each waiting core is granted within NREQ transactions.

Decomposition:
- Shared package ucore_pkg:
  - State encodings UARB_IDLE=0, UARB_ISSUE=1, UARB_WAIT_RSP=2 (2-bit state register).
  - Width constant for the timeout counter.
- One sub-module: ucore_rr_pick, combinational.
  - Inputs: NREQ request vector, last_grant.
  - Outputs: winner index, any_valid.
  - Reused by future shared-resource arbiters.

Test Plan:
- Single read: core 2 req addr 0x40 at T; mem_req_ready=1 at T+1; mem_rsp_valid with 0xDEADBEEF at T+3 -> req_ready[2]=1 at T+1; rsp_valid[2]=1 with rsp_rdata=0xDEADBEEF, rsp_err=0 at T+4; busy low at T+4.
- Round-robin fairness: cores 0, 1, 3 all requesting continuously, memory 1-cycle response -> grant order 0,1,3,0,1,3; core 2 never granted; no core waits more than 3 transactions.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and mem_addr/mem_wdata stable across all 5 cycles; req_ready pulses only once.
- Timeout: TIMEOUT=4, no memory response -> rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0 exactly 5 cycles after the request handshake; a later mem_rsp_valid sets err_spurious=1.
- Response/timeout collision: mem_rsp_valid on the cycle the counter reaches TIMEOUT -> rsp_err=0, data delivered.
- Reset mid-operation: aresetn low during WAIT_RSP -> all outputs 0 immediately; after release core 0 wins a simultaneous 0/1 request.

Source files
------------

// File: rtl/ucore_pkg.sv
// ucore_pkg: shared encodings for the ucore shared-resource arbiters
package ucore_pkg;
  typedef enum logic [1:0] {
    UARB_IDLE     = 2'd0,
    UARB_ISSUE    = 2'd1,
    UARB_WAIT_RSP = 2'd2
  } uarb_state_e;
  localparam int UARB_CNT_W = 16;
endpackage

// File: rtl/ucore_rr_pick.sv
// ucore_rr_pick: combinational round-robin pick starting after last_grant
module ucore_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_grant_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    any_valid_o
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] idx;
  // scan farthest-first so the nearest requester after last_grant overwrites
  always_comb begin
    winner_o = '0;
    idx = '0;
    any_valid_o = |req_i;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant_i) + k) % NREQ);
      if (req_i[idx]) winner_o = idx;
    end
  end
endmodule

// File: rtl/ucore_mem_arbiter.sv
// ucore_mem_arbiter: round-robin share of one memory port, one transaction in flight
module ucore_mem_arbiter
  import ucore_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]  req_wen,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wen,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             err_spurious
);
  localparam int IW = $clog2(NREQ);
  uarb_state_e           state_q;
  logic [IW-1:0]         last_grant_q, owner_q, winner;
  logic [UARB_CNT_W-1:0] cnt_q;
  logic                  any_valid, timeout_hit;
  logic [NREQ-1:0]       req_ready_q, rsp_valid_q;
  logic [DW-1:0]         rsp_rdata_q, mem_wdata_q;
  logic [AW-1:0]         mem_addr_q;
  logic                  rsp_err_q, mem_req_valid_q, mem_wen_q, busy_q, err_spurious_q;

  ucore_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i       (req_valid),
    .last_grant_i(last_grant_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // the counter reaches TIMEOUT on this edge, so the error goes out next cycle
  assign timeout_hit = cnt_q == UARB_CNT_W'(TIMEOUT - 1);

  // arbitration, memory handshake and response routing in one registered FSM
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= UARB_IDLE;
      last_grant_q    <= IW'(NREQ - 1);
      owner_q         <= '0;
      cnt_q           <= '0;
      req_ready_q     <= '0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      err_spurious_q  <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      if (mem_rsp_valid && state_q != UARB_WAIT_RSP) err_spurious_q <= 1'b1;
      case (state_q)
        UARB_IDLE: if (any_valid) begin
          state_q         <= UARB_ISSUE;
          owner_q         <= winner;
          last_grant_q    <= winner;
          req_ready_q     <= NREQ'(1) << winner;
          mem_req_valid_q <= 1'b1;
          mem_addr_q      <= AW'(req_addr >> (int'(winner) * AW));
          mem_wen_q       <= req_wen[winner];
          mem_wdata_q     <= DW'(req_wdata >> (int'(winner) * DW));
          busy_q          <= 1'b1;
        end
        UARB_ISSUE: if (mem_req_ready) begin
          state_q         <= UARB_WAIT_RSP;
          mem_req_valid_q <= 1'b0;
          cnt_q           <= '0;
        end
        UARB_WAIT_RSP: begin
          cnt_q <= cnt_q + UARB_CNT_W'(1);
          if (mem_rsp_valid || timeout_hit) begin
            state_q     <= UARB_IDLE;
            rsp_valid_q <= NREQ'(1) << owner_q;
            rsp_rdata_q <= mem_rsp_valid ? mem_rdata : '0;
            rsp_err_q   <= !mem_rsp_valid;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q         <= UARB_IDLE;
          mem_req_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign err_spurious  = err_spurious_q;
endmodule
